// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_types_pkg : shared CPU word, predictor counter and BTB entry types|
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  bpctr_t;

  // Tag field is full width; each BTB compares only the bits its size needs.
  typedef struct packed {
    logic   valid;
    word_t  tag;
    word_t  target;
    bpctr_t ctr;
  } btb_entry_t;

  localparam bpctr_t BPCTR_SN = 2'b00;
  localparam bpctr_t BPCTR_WN = 2'b01;
  localparam bpctr_t BPCTR_WT = 2'b10;
  localparam bpctr_t BPCTR_ST = 2'b11;

  function automatic bpctr_t bpctr_update(input bpctr_t ctr, input logic taken);
    bpctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != BPCTR_ST) result = ctr + 2'd1;
    end else begin
      if (ctr != BPCTR_SN) result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_counter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | program_counter_if : fetch PC, prediction and branch-resolution bus   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface program_counter_if;
  import cpu_types_pkg::*;

  logic  ihit;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  res_valid;
  word_t res_pc;
  logic  res_taken;
  word_t res_target;

  word_t imemaddr;
  word_t nPC;
  logic  pred_taken;
  word_t pred_target;

  modport pc (
    input  ihit, stall, redirect, redirect_pc,
    input  res_valid, res_pc, res_taken, res_target,
    output imemaddr, nPC, pred_taken, pred_target
  );

  modport dp (
    output ihit, stall, redirect, redirect_pc,
    output res_valid, res_pc, res_taken, res_target,
    input  imemaddr, nPC, pred_taken, pred_target
  );

endinterface
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | branch_target_buffer : direct-mapped BTB, 2-bit counters, no bypass   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire word_t lookup_pc,
  output logic       lookup_taken,
  output word_t      lookup_target,
  input  wire logic  train_valid,
  input  wire word_t train_pc,
  input  wire logic  train_taken,
  input  wire word_t train_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX;

  btb_entry_t entries [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_entry;
  logic             lk_hit;

  logic [IDX-1:0]   tr_idx;
  logic [TAG_W-1:0] tr_tag;
  btb_entry_t       tr_entry;
  logic             tr_hit;

  assign lk_idx   = lookup_pc[IDX+1:2];
  assign lk_tag   = lookup_pc[31:IDX+2];
  assign lk_entry = entries[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag[TAG_W-1:0] == lk_tag);

  assign lookup_taken  = lk_hit && lk_entry.ctr[1];
  assign lookup_target = lk_entry.target;

  assign tr_idx   = train_pc[IDX+1:2];
  assign tr_tag   = train_pc[31:IDX+2];
  assign tr_entry = entries[tr_idx];
  assign tr_hit   = tr_entry.valid && (tr_entry.tag[TAG_W-1:0] == tr_tag);

  // Only the valid bits are cleared; stale payload is masked by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else if (train_valid) begin
      if (tr_hit) begin
        entries[tr_idx].ctr <= bpctr_update(tr_entry.ctr, train_taken);
        if (train_taken) begin
          entries[tr_idx].target <= train_target;
        end
      end else if (train_taken) begin
        entries[tr_idx] <= '{valid:  1'b1,
                             tag:    word_t'(tr_tag),
                             target: train_target,
                             ctr:    BPCTR_WT};
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], train_pc[1:0],
                         lk_entry.tag[31:TAG_W], lk_entry.ctr[0],
                         tr_entry.tag[31:TAG_W], tr_entry.target};

endmodule
`default_nettype wire

// File: rtl/program_counter_bp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | program_counter_bp : fetch PC register with BTB-driven next-PC mux    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module program_counter_bp
  import cpu_types_pkg::*;
#(
  parameter int    BTB_ENTRIES = 16,
  parameter word_t PC_RESET    = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  program_counter_if.pc  pcif
);

  word_t pc_reg;
  word_t pc_next;
  word_t seq_pc;
  logic  btb_taken;
  word_t btb_target;
  logic  pred_taken;
  word_t pred_target;

  assign seq_pc = pc_reg + 32'd4;

  branch_target_buffer #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_reg),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .train_valid   (pcif.res_valid),
    .train_pc      (pcif.res_pc),
    .train_taken   (pcif.res_taken),
    .train_target  (pcif.res_target)
  );

  // Masking with rst keeps the prediction quiet before valid bits settle.
  assign pred_taken  = btb_taken && !rst;
  assign pred_target = pred_taken ? btb_target : seq_pc;

  always_comb begin
    pc_next = pc_reg;
    if (pcif.redirect) begin
      pc_next = pcif.redirect_pc;
    end else if (pcif.ihit && !pcif.stall) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= PC_RESET;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pcif.imemaddr    = pc_reg;
  assign pcif.nPC         = seq_pc;
  assign pcif.pred_taken  = pred_taken;
  assign pcif.pred_target = pred_target;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_bp.sv
`default_nettype none
// Self-checking bench: abstract BTB/PC model compared every cycle, plus directed literals.
module tb_program_counter_bp;
  import cpu_types_pkg::*;

  localparam int          N      = 16;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_counter_if pcif();

  program_counter_bp #(
    .BTB_ENTRIES (N),
    .PC_RESET    (PC_RST)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pcif (pcif)
  );

  int checks   = 0;
  int failures = 0;

  // Model: per slot, the word address of the last branch placed there.
  bit          model_valid = 1'b0;
  logic [31:0] m_pc;
  bit          m_v    [N];
  logic [29:0] m_line [N];
  logic [31:0] m_tgt  [N];
  int          m_cnt  [N];

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[slot(a)] && (m_line[slot(a)] == a[31:2]);
  endfunction

  function automatic bit m_taken(input logic [31:0] a);
    return !rst && m_hit(a) && (m_cnt[slot(a)] >= 2);
  endfunction

  function automatic logic [31:0] m_predict(input logic [31:0] a);
    return m_taken(a) ? m_tgt[slot(a)] : a + 32'd4;
  endfunction

  task automatic model_step();
    logic [31:0] nxt;
    int          k;
    if (rst) begin
      m_pc = PC_RST;
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      nxt = m_pc;
      if (pcif.redirect) nxt = pcif.redirect_pc;
      else if (pcif.ihit && !pcif.stall) nxt = m_predict(m_pc);
      if (pcif.res_valid) begin
        k = slot(pcif.res_pc);
        if (m_hit(pcif.res_pc)) begin
          if (pcif.res_taken) begin
            m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
            m_tgt[k] = pcif.res_target;
          end else begin
            m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
          end
        end else if (pcif.res_taken) begin
          m_v[k]    = 1'b1;
          m_line[k] = pcif.res_pc[31:2];
          m_tgt[k]  = pcif.res_target;
          m_cnt[k]  = 2;
        end
      end
      m_pc = nxt;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("imemaddr",    pcif.imemaddr, m_pc);
      chk("nPC",         pcif.nPC, m_pc + 32'd4);
      chk("pred_taken",  {31'd0, pcif.pred_taken}, {31'd0, m_taken(m_pc)});
      chk("pred_target", pcif.pred_target, m_predict(m_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    pcif.ihit = 1'b0;        pcif.stall = 1'b0;
    pcif.redirect = 1'b0;    pcif.redirect_pc = '0;
    pcif.res_valid = 1'b0;   pcif.res_pc = '0;
    pcif.res_taken = 1'b0;   pcif.res_target = '0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    pcif.redirect = 1'b1; pcif.redirect_pc = a;
    tick();
    pcif.redirect = 1'b0;
  endtask

  task automatic train(input logic [31:0] a, input logic tk, input logic [31:0] tgt);
    pcif.res_valid = 1'b1; pcif.res_pc = a; pcif.res_taken = tk; pcif.res_target = tgt;
    tick();
    pcif.res_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
      | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
    return a;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    tick();
    chk("rst_imemaddr", pcif.imemaddr, 32'h0);
    chk("rst_nPC", pcif.nPC, 32'h4);
    chk("rst_pred_taken", {31'd0, pcif.pred_taken}, 32'd0);
    chk("rst_pred_target", pcif.pred_target, 32'h4);

    rst = 1'b0;
    pcif.ihit = 1'b1;
    tick(); chk("seq_4", pcif.imemaddr, 32'h4);
    tick(); chk("seq_8", pcif.imemaddr, 32'h8);
    tick(); chk("seq_c", pcif.imemaddr, 32'hC);
    chk("seq_pred", {31'd0, pcif.pred_taken}, 32'd0);
    pcif.ihit = 1'b0;

    // Allocate a taken branch and fetch through it.
    train(32'h40, 1'b1, 32'h100);
    redirect_to(32'h40);
    chk("alloc_pred", {31'd0, pcif.pred_taken}, 32'd1);
    chk("alloc_tgt", pcif.pred_target, 32'h100);
    pcif.ihit = 1'b1; tick(); pcif.ihit = 1'b0;
    chk("follow_tgt", pcif.imemaddr, 32'h100);

    // Two not-taken outcomes: 10 -> 01 -> 00.
    train(32'h40, 1'b0, 32'h0);
    train(32'h40, 1'b0, 32'h0);
    redirect_to(32'h40);
    chk("nt_pred", {31'd0, pcif.pred_taken}, 32'd0);
    chk("nt_tgt", pcif.pred_target, 32'h44);
    pcif.ihit = 1'b1; tick(); pcif.ihit = 1'b0;
    chk("nt_seq", pcif.imemaddr, 32'h44);

    // Redirect beats stall; without redirect a stalled PC holds.
    pcif.ihit = 1'b1; pcif.stall = 1'b1;
    redirect_to(32'h200);
    chk("redir_stall", pcif.imemaddr, 32'h200);
    tick();
    chk("stall_hold", pcif.imemaddr, 32'h200);
    pcif.ihit = 1'b0; pcif.stall = 1'b0;

    // Re-train to weakly taken, then check an aliasing fetch misses.
    train(32'h40, 1'b1, 32'h100);
    train(32'h40, 1'b1, 32'h100);
    redirect_to(32'h40);
    chk("retrain_pred", {31'd0, pcif.pred_taken}, 32'd1);
    redirect_to(32'h440);
    chk("alias_pred", {31'd0, pcif.pred_taken}, 32'd0);
    chk("alias_tgt", pcif.pred_target, 32'h444);

    // Saturation: 10 -> 11 -> 11 -> 11, then one not-taken leaves 10.
    train(32'h40, 1'b1, 32'h180);
    train(32'h40, 1'b1, 32'h180);
    train(32'h40, 1'b1, 32'h180);
    train(32'h40, 1'b0, 32'h0);
    redirect_to(32'h40);
    chk("sat_pred", {31'd0, pcif.pred_taken}, 32'd1);
    chk("sat_tgt", pcif.pred_target, 32'h180);

    // Address wrap, then reset overriding redirect and training.
    redirect_to(32'hFFFF_FFFC);
    pcif.ihit = 1'b1; tick(); pcif.ihit = 1'b0;
    chk("wrap", pcif.imemaddr, 32'h0);
    rst = 1'b1;
    pcif.redirect = 1'b1; pcif.redirect_pc = 32'h300;
    pcif.res_valid = 1'b1; pcif.res_pc = 32'h80; pcif.res_taken = 1'b1; pcif.res_target = 32'h180;
    tick();
    chk("rst_over_redir", pcif.imemaddr, PC_RST);
    rst = 1'b0;
    idle();
    redirect_to(32'h40);
    chk("rst_clr_valid", {31'd0, pcif.pred_taken}, 32'd0);
    redirect_to(32'h80);
    chk("rst_over_train", {31'd0, pcif.pred_taken}, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 99) == 0);
      pcif.ihit        = ($urandom_range(0, 3) != 0);
      pcif.stall       = ($urandom_range(0, 3) == 0);
      pcif.redirect    = ($urandom_range(0, 7) == 0);
      pcif.redirect_pc = rand_addr();
      pcif.res_valid   = ($urandom_range(0, 2) == 0);
      pcif.res_pc      = rand_addr();
      pcif.res_taken   = ($urandom_range(0, 2) != 0);
      pcif.res_target  = rand_addr();
      tick();
    end

    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_counter_bp.md
PROGRAM_COUNTER_BP -- requirements
Module: program_counter_bp

Interface
REQ-001 Parameter BTB_ENTRIES, default 16: direct-mapped branch-target-buffer entries; power of two, 4..256.
REQ-002 Parameter PC_RESET, default 32'h0000_0000: fetch address after reset.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ihit  in  1  instruction memory returned the word at imemaddr this cycle.
REQ-006 stall  in  1  pipeline hazard hold; fetch PC must not advance.
REQ-007 redirect  in  1  EX/MEM resolved a mispredict, jump or jr; load redirect_pc.
REQ-008 redirect_pc  in  32  word_t corrected fetch address.
REQ-009 res_valid  in  1  a branch resolved this cycle; train the BTB.
REQ-010 res_pc  in  32  word_t address of the resolved branch.
REQ-011 res_taken  in  1  actual branch outcome.
REQ-012 res_target  in  32  word_t actual taken target.
REQ-013 imemaddr  out  32  word_t current fetch PC.
REQ-014 nPC  out  32  word_t imemaddr + 4, carried down the pipe.
REQ-015 pred_taken  out  1  BTB hit with counter MSB = 1 for imemaddr.
REQ-016 pred_target  out  32  word_t predicted target; equals nPC when pred_taken = 0.

Function
REQ-017 IDX = log2(BTB_ENTRIES); index = pc[IDX+1:2], tag = pc[31:IDX+2]; pc[1:0] is ignored.
REQ-018 Lookup is combinational on imemaddr: hit = valid[index] and tag match; pred_taken = hit and ctr[1].
REQ-019 PC update priority: RST, then redirect, then (ihit and not stall), then hold.
REQ-020 Redirect loads redirect_pc on the next edge regardless of ihit or stall.
REQ-021 On advance, next PC = pred_target if pred_taken, else imemaddr + 4; addition wraps modulo 2^32.
REQ-022 Training on res_valid, when the entry is valid with a tag match: ctr saturating +1 if taken, else -1; target <= res_target if taken.
REQ-023 Training on res_valid with a miss and res_taken = 1: allocate the entry (overwrite) with valid = 1, tag, target and ctr = 2'b10.
REQ-024 Training on res_valid with a miss and res_taken = 0: no BTB change.
REQ-025 Counter saturates at 2'b11 and 2'b00 with no wrap.
REQ-026 BTB write takes effect at the edge; a lookup in the same cycle to the same index sees the old entry (no bypass).
REQ-027 res_valid trains independently of stall, ihit and redirect; training and redirect in the same cycle both take effect.
REQ-028 No output depends combinationally on res_* or redirect inputs.

Reset
REQ-029 On RST: imemaddr = PC_RESET, nPC = PC_RESET + 4, and all valid bits = 0.
REQ-030 While RST is held, pred_taken = 0 and pred_target = nPC.
REQ-031 Tags, targets and counters need not be reset; they shall be unobservable while invalid.
REQ-032 RST asserted mid-operation overrides a simultaneous redirect or training the same cycle.

Structure
REQ-033 cpu_types_pkg gains: typedef bpctr_t (2-bit), typedef btb_entry_t struct {valid, tag, target, ctr}, and localparams BPCTR_WT = 2'b10, BPCTR_ST = 2'b11.
REQ-034 Tag width is derived from BTB_ENTRIES inside the module; the package holds a 32-bit tag field, and upper unused bits are ignored.
REQ-035 One sub-module, branch_target_buffer, holds the array, lookup and training; program_counter_bp holds the PC register and next-PC mux.
REQ-036 program_counter_if is extended with pred_taken, pred_target and the res_* and redirect signals, with pc and dp modports updated to match.

Verification
REQ-037 RST one cycle then ihit = 1 for 3 cycles -> imemaddr 0x0, 0x4, 0x8, 0xC; pred_taken = 0 throughout.
REQ-038 res_valid with res_pc = 0x40, taken, target 0x100; later fetch reaches 0x40 -> pred_taken = 1, next imemaddr = 0x100.
REQ-039 Same branch then trained not-taken twice -> ctr goes 10, 01, 00; fetch at 0x40 gives pred_taken = 0 and next PC 0x44.
REQ-040 ihit = 1, stall = 1, redirect = 1 with redirect_pc = 0x200 -> imemaddr = 0x200 next cycle; with redirect = 0 instead, the PC holds.
REQ-041 Alias test: train 0x40 taken, then fetch 0x440 (same index, different tag; BTB_ENTRIES = 16) -> pred_taken = 0.
REQ-042 imemaddr = 0xFFFF_FFFC with ihit -> next imemaddr = 0x0; RST during a redirect -> imemaddr = PC_RESET.
